booth_seq_ctrl: RTL and testbench

- Sequential radix-2 Booth multiplier controller for signed operands.
- Accepts one operand pair over a valid/ready handshake and iterates the Booth add/sub/arithmetic-shift step once per clock for WIDTH cycles.
- Holds the 2*WIDTH-bit signed product under an output valid/ready handshake.
- Sits between the issue logic and the result bus. Lets one step datapath replace a WIDTH-deep combinational chain of step instances.

---
 rtl/booth_seq_ctrl_if.sv | 27 ++
 rtl/booth_seq_ctrl.sv | 105 ++++++++++
 tb/tb_booth_seq_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/booth_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential Booth multiplier.
// The master side issues operands and consumes products. The slave side is the controller.
interface booth_seq_ctrl_if #(
    parameter int WIDTH = 32
) ();
    localparam int CW = $clog2(WIDTH + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;
    logic [CW-1:0]          step_count;

    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product, busy, step_count
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product, busy, step_count
    );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller.
// Performs one add/sub plus arithmetic-shift step per clock for WIDTH clocks.
// The signed product is then held until the consumer takes it.
module booth_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    booth_seq_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    // A and M carry one guard bit so that negating -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH:0]       t;

    // Booth recoding of {Q[0], Q_1}: add M, subtract M, or pass A through.
    always_comb begin
        t = a_q;
        unique case ({q_q[0], q1_q})
            2'b01:   t = a_q + m_q;
            2'b10:   t = a_q - m_q;
            default: t = a_q;
        endcase
    end

    // Next-state logic: accept in IDLE, step in RUN, hold the product in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = '0;
                    m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
                    q_d     = bus.multiplier;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Arithmetic right shift of {T, Q, Q_1}.
                a_d   = {t[WIDTH], t[WIDTH:1]};
                q_d   = {t[0], q_q[WIDTH-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Capture the product on the final step so it survives the next accept.
                    prod_d  = {a_d[WIDTH-1:0], q_d};
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        bus.in_ready   = (state_q == StIdle);
        bus.busy       = (state_q != StIdle);
        bus.out_valid  = (state_q == StDone);
        bus.product    = prod_q;
        bus.step_count = cnt_q;
    end
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl (WIDTH=32).
// A cycle-level reference model predicts every output. Directed cases pin exact literal products.
module tb_booth_seq_ctrl;
    localparam int W  = 32;
    localparam int CW = $clog2(W + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    booth_seq_ctrl_if #(.WIDTH(W)) bus_if ();

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model: elapsed cycles since accept plus the expected signed product.
    bit          m_active  = 1'b0;
    int          m_elapsed = 0;
    logic [63:0] m_exp     = '0;
    logic [63:0] m_hold    = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Model update on each active edge, from the inputs that the bench held across that edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_active  = 1'b0;
            m_elapsed = 0;
            m_exp     = '0;
            m_hold    = '0;
        end else if (!m_active) begin
            if (bus_if.in_valid) begin
                m_active  = 1'b1;
                m_elapsed = 0;
                m_exp     = smul(bus_if.multiplicand, bus_if.multiplier);
            end
        end else if (m_elapsed < W) begin
            m_elapsed++;
        end else if (bus_if.out_ready) begin
            m_active = 1'b0;
            m_hold   = m_exp;
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        bit dn;
        if (chk_en) begin
            dn = m_active && (m_elapsed >= W);
            chk("in_ready",   64'(bus_if.in_ready),   64'(!m_active));
            chk("busy",       64'(bus_if.busy),       64'(m_active));
            chk("out_valid",  64'(bus_if.out_valid),  64'(dn));
            chk("step_count", 64'(bus_if.step_count), 64'(m_elapsed));
            chk("product",    bus_if.product,         dn ? m_exp : m_hold);
        end
    end

    // Present operands until they are accepted. Returns with in_valid low, one tick after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        bit rdy;
        ok = 1'b0;
        bus_if.multiplicand = a;
        bus_if.multiplier   = b;
        bus_if.in_valid     = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            rdy = bus_if.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bus_if.in_valid = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready within 200 cycles");
        end
    endtask

    // Count edges from accept until out_valid is seen.
    task automatic wait_result(input bit rnd_ready, output int lat);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid) begin
                lat = n;
                break;
            end
            if (rnd_ready) bus_if.out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic release_out();
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [63:0] exp_lit);
        bit ok;
        int lat;
        issue(a, b, ok);
        if (ok) begin
            wait_result(1'b0, lat);
            chk({nm, "_latency"}, 64'(lat), 64'(W));
            chk(nm, bus_if.product, exp_lit);
            chk({nm, "_steps"}, 64'(bus_if.step_count), 64'(W));
            release_out();
        end
    endtask

    initial begin
        bit          ok;
        int          lat;
        logic [63:0] snap;
        logic [W-1:0] ra, rb;

        bus_if.in_valid     = 1'b0;
        bus_if.multiplicand = '0;
        bus_if.multiplier   = '0;
        bus_if.out_ready    = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset_in_ready",  64'(bus_if.in_ready),   64'd1);
        chk("reset_product",   bus_if.product,         64'd0);
        chk("reset_steps",     64'(bus_if.step_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed products with hand-computed results.
        op("mul_7_m3",        32'd7,          -32'sd3,        64'hFFFF_FFFF_FFFF_FFEB);
        op("mul_min_min",     32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
        op("mul_min_1",       32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000);
        op("mul_max_0",       32'h7FFF_FFFF,  32'd0,          64'h0);
        op("mul_max_max",     32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001);
        op("mul_max_min",     32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000);
        op("mul_m1_m1",       32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'd1);

        // Backpressure in DONE, with a stray in_valid pulse that must be ignored.
        bus_if.out_ready = 1'b0;
        issue(32'd3, 32'd4, ok);
        wait_result(1'b0, lat);
        chk("bp_latency", 64'(lat), 64'(W));
        chk("bp_product", bus_if.product, 64'd12);
        snap = bus_if.product;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus_if.multiplicand = 32'd9;
                bus_if.multiplier   = 32'd9;
                bus_if.in_valid     = 1'b1;
            end else begin
                bus_if.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("bp_hold_valid",    64'(bus_if.out_valid), 64'd1);
            chk("bp_hold_product",  bus_if.product,        snap);
            chk("bp_hold_in_ready", 64'(bus_if.in_ready),  64'd0);
        end
        bus_if.in_valid = 1'b0;
        release_out();
        chk("bp_release_in_ready",  64'(bus_if.in_ready),  64'd1);
        chk("bp_release_out_valid", 64'(bus_if.out_valid), 64'd0);

        // Reset in the middle of an operation aborts it.
        issue(32'd123, 32'd456, ok);
        repeat (15) @(posedge clk);
        #1;
        chk("abort_steps_before", 64'(bus_if.step_count), 64'd15);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_in_ready",  64'(bus_if.in_ready),   64'd1);
        chk("abort_out_valid", 64'(bus_if.out_valid),  64'd0);
        chk("abort_busy",      64'(bus_if.busy),       64'd0);
        chk("abort_steps",     64'(bus_if.step_count), 64'd0);
        chk("abort_product",   bus_if.product,         64'd0);
        op("mul_5_6", 32'd5, 32'd6, 64'd30);

        // Random pairs with random issue gaps and consumer stalls.
        for (int k = 0; k < 300; k++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : W'($urandom);
            if ($urandom_range(0, 9) == 0) rb = 32'hFFFF_FFFF;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            issue(ra, rb, ok);
            if (!ok) break;
            wait_result(1'b1, lat);
            chk("rnd_latency", 64'(lat), 64'(W));
            chk("rnd_product", bus_if.product, smul(ra, rb));
            bus_if.out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            release_out();
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
